// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, sends start/8 data/odd parity/stop
// on device clock falling edges, then reads the device ACK bit. Watchdog aborts stalled transfers.
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic [7:0] tx_data,
  input  logic       tx_start,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error,
  output logic [2:0] o_dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_INHIBIT  = 3'd1,
    S_SEND     = 3'd2,
    S_ACK      = 3'd3,
    S_WAIT_REL = 3'd4
  } state_t;

  localparam logic [19:0] INH_LAST  = 20'(INHIBIT_CYCLES - 1);
  localparam logic [19:0] INH_PRE   = 20'(INHIBIT_CYCLES - 2);
  localparam logic [19:0] WDOG_LAST = 20'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  logic [19:0] r_inh_cnt;
  logic [19:0] r_wdog;
  logic [3:0]  r_bit_idx;
  logic [7:0]  r_data;
  logic        r_parity;
  logic        r_clk_oe;
  logic        r_dat_oe;
  logic        r_busy;
  logic        r_done;
  logic        r_error;

  logic        r_clk_meta, r_clk_sync, r_clk_prev;
  logic        r_dat_meta, r_dat_sync;
  logic        w_clk_fall;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_clk_meta <= 1'b1;
      r_clk_sync <= 1'b1;
      r_clk_prev <= 1'b1;
      r_dat_meta <= 1'b1;
      r_dat_sync <= 1'b1;
    end else begin
      r_clk_meta <= ps2_clk_in;
      r_clk_sync <= r_clk_meta;
      r_clk_prev <= r_clk_sync;
      r_dat_meta <= ps2_dat_in;
      r_dat_sync <= r_dat_meta;
    end
  end

  assign w_clk_fall = r_clk_prev & ~r_clk_sync;

  // Handshake: tx_start is sampled on a rising Clk edge only while tx_busy=0;
  // tx_data is captured on that same edge and ignored at all other times.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state   <= S_IDLE;
      r_inh_cnt <= '0;
      r_wdog    <= '0;
      r_bit_idx <= '0;
      r_data    <= '0;
      r_parity  <= 1'b0;
      r_clk_oe  <= 1'b0;
      r_dat_oe  <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_error   <= 1'b0;
    end else begin
      r_done  <= 1'b0;
      r_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (tx_start) begin
            r_data    <= tx_data;
            r_parity  <= ~^tx_data;
            r_inh_cnt <= '0;
            r_wdog    <= '0;
            r_bit_idx <= '0;
            r_clk_oe  <= 1'b1;
            r_dat_oe  <= 1'b0;
            r_busy    <= 1'b1;
            r_state   <= S_INHIBIT;
          end
        end
        S_INHIBIT: begin
          if (r_inh_cnt == INH_LAST) begin
            r_clk_oe  <= 1'b0;
            r_dat_oe  <= 1'b1;
            r_wdog    <= '0;
            r_bit_idx <= '0;
            r_state   <= S_SEND;
          end else begin
            r_inh_cnt <= r_inh_cnt + 20'd1;
            if (r_inh_cnt == INH_PRE) r_dat_oe <= 1'b1;
          end
        end
        S_SEND, S_ACK, S_WAIT_REL: begin
          // Watchdog spans the whole device-clocked phase and beats any edge event.
          if (r_wdog == WDOG_LAST) begin
            r_clk_oe <= 1'b0;
            r_dat_oe <= 1'b0;
            r_error  <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_wdog <= r_wdog + 20'd1;
            if (r_state == S_SEND) begin
              if (w_clk_fall) begin
                r_bit_idx <= r_bit_idx + 4'd1;
                if (r_bit_idx <= 4'd7) begin
                  r_dat_oe <= ~r_data[r_bit_idx[2:0]];
                end else if (r_bit_idx == 4'd8) begin
                  r_dat_oe <= ~r_parity;
                end else begin
                  r_dat_oe <= 1'b0;
                  r_state  <= S_ACK;
                end
              end
            end else if (r_state == S_ACK) begin
              if (w_clk_fall) begin
                r_done  <= ~r_dat_sync;
                r_error <= r_dat_sync;
                r_state <= S_WAIT_REL;
              end
            end else begin
              if (r_clk_sync && r_dat_sync) begin
                r_busy  <= 1'b0;
                r_state <= S_IDLE;
              end
            end
          end
        end
        default: begin
          r_clk_oe <= 1'b0;
          r_dat_oe <= 1'b0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign ps2_clk_oe  = r_clk_oe;
  assign ps2_dat_oe  = r_dat_oe;
  assign tx_busy     = r_busy;
  assign tx_done     = r_done;
  assign tx_error    = r_error;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a keyboard model clocks frames over a wired-AND bus,
// captures the bits the host puts on the data line, and answers ACK/NACK/hold/no-clock.
`timescale 1ns/1ps
module tb_ps2_host_tx;
  localparam int INH  = 16;
  localparam int TMO  = 2000;
  localparam int HALF = 20;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic [7:0] tx_data;
  logic       tx_start;
  logic       kbd_clk = 1'b1;
  logic       kbd_dat = 1'b1;
  logic       ps2_clk_line, ps2_dat_line;
  logic       ps2_clk_oe, ps2_dat_oe, tx_busy, tx_done, tx_error;
  logic [2:0] dbg_state;

  assign ps2_clk_line = kbd_clk & ~ps2_clk_oe;
  assign ps2_dat_line = kbd_dat & ~ps2_dat_oe;

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (
    .Clk(clk), .Reset_n(rst_n), .tx_data(tx_data), .tx_start(tx_start),
    .ps2_clk_in(ps2_clk_line), .ps2_dat_in(ps2_dat_line),
    .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe), .tx_busy(tx_busy),
    .tx_done(tx_done), .tx_error(tx_error), .o_dbg_state(dbg_state)
  );

  int errors = 0;
  int checks = 0;
  int n_done = 0, n_error = 0, n_both = 0;

  always @(negedge clk) begin
    if (tx_done) n_done++;
    if (tx_error) n_error++;
    if (tx_done && tx_error) n_both++;
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
    $fatal(1, "global timeout");
  end

  // driver tasks
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic start_tx(input logic [7:0] d);
    tx_data  = d;
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
  endtask

  task automatic run_inhibit(input string tag);
    int   hi = 0;
    int   dat_hi = 0;
    int   guard = 0;
    logic last_dat = 1'b0;
    while (!ps2_clk_oe && guard < 50) begin @(negedge clk); guard++; end
    while (ps2_clk_oe && hi < 100) begin
      hi++;
      if (ps2_dat_oe) dat_hi++;
      last_dat = ps2_dat_oe;
      @(negedge clk);
    end
    check({tag, " inhibit_len"}, hi, INH);
    check({tag, " inhibit_dat_cycles"}, dat_hi, 1);
    check({tag, " inhibit_last_dat"}, {31'd0, last_dat}, 1);
    check({tag, " start_bit_held"}, {31'd0, ps2_dat_oe}, 1);
    check({tag, " send_state"}, {29'd0, dbg_state}, 2);
  endtask

  // Keyboard model: 11 falls; bits[k] sampled on rise k, bits[0] is the start bit.
  task automatic kbd_frame(input string tag, input logic ack, input int hold,
                           input int inject_k, input int abort_k,
                           output logic [10:0] bits, output logic aborted);
    bits = '0;
    aborted = 1'b0;
    tick(10);
    bits[0] = ps2_dat_line;
    for (int k = 1; k <= 11; k++) begin
      kbd_clk = 1'b0;
      tick(HALF / 2);
      if (k == inject_k) begin
        tx_data  = 8'h00;
        tx_start = 1'b1;
        tick(2);
        tx_start = 1'b0;
      end else begin
        tick(2);
      end
      if (k == abort_k) begin
        check({tag, " pre_reset_dat_oe"}, {31'd0, ps2_dat_oe}, 1);
        #2 rst_n = 1'b0;
        #1;
        check({tag, " async_clk_oe"}, {31'd0, ps2_clk_oe}, 0);
        check({tag, " async_dat_oe"}, {31'd0, ps2_dat_oe}, 0);
        check({tag, " async_busy"}, {31'd0, tx_busy}, 0);
        kbd_clk = 1'b1;
        kbd_dat = 1'b1;
        aborted = 1'b1;
        break;
      end
      tick(HALF / 2 - 2);
      kbd_clk = 1'b1;
      if (k <= 10) bits[k] = ps2_dat_line;
      if (k == 10 && ack) kbd_dat = 1'b0;
      tick(HALF);
    end
    if (!aborted) begin
      if (hold > 0) begin
        tick(hold / 2);
        check({tag, " wait_rel_busy"}, {31'd0, tx_busy}, 1);
        check({tag, " wait_rel_state"}, {29'd0, dbg_state}, 4);
        tick(hold / 2);
      end
      kbd_dat = 1'b1;
    end
  endtask

  // scoreboard: expected frames queued up front, popped per transfer
  logic [10:0] exp_q[$];
  logic [10:0] bits;
  logic        ab;
  int          base_d, base_e, t;

  task automatic send_and_check(input string tag, input logic [7:0] d, input logic ack,
                                input int hold, input int inject_k);
    logic [10:0] exp_bits;
    logic [10:0] got;
    logic        got_ab;
    base_d = n_done;
    base_e = n_error;
    exp_bits = exp_q.pop_front();
    start_tx(d);
    run_inhibit(tag);
    kbd_frame(tag, ack, hold, inject_k, 0, got, got_ab);
    check({tag, " frame_bits"}, {21'd0, got}, {21'd0, exp_bits});
    tick(6);
    check({tag, " done_count"}, n_done - base_d, ack ? 1 : 0);
    check({tag, " error_count"}, n_error - base_e, ack ? 0 : 1);
    check({tag, " busy_after"}, {31'd0, tx_busy}, 0);
    check({tag, " idle_after"}, {29'd0, dbg_state}, 0);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_start = 1'b0;
    tx_data  = 8'h00;
    // frame layout {stop, parity, data[7:0], start}, parity hand-computed (odd)
    exp_q.push_back({1'b1, 1'b1, 8'hED, 1'b0});
    exp_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});
    exp_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
    exp_q.push_back({1'b1, 1'b0, 8'h01, 1'b0});
    exp_q.push_back({1'b1, 1'b1, 8'hFF, 1'b0});
    exp_q.push_back({1'b1, 1'b0, 8'hF4, 1'b0});

    tick(3);
    check("reset clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("reset dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("reset busy", {31'd0, tx_busy}, 0);
    check("reset done", {31'd0, tx_done}, 0);
    check("reset error", {31'd0, tx_error}, 0);
    check("reset state", {29'd0, dbg_state}, 0);
    rst_n = 1'b1;
    tick(2);

    send_and_check("ed_ack", 8'hED, 1'b1, 0, 0);
    send_and_check("f4_nack", 8'hF4, 1'b0, 0, 0);

    // device never clocks: watchdog fires TMO cycles after SEND entry
    base_d = n_done;
    base_e = n_error;
    start_tx(8'hAA);
    run_inhibit("timeout");
    t = 0;
    while (!tx_error && t < 3000) begin @(negedge clk); t++; end
    check("timeout latency", t, TMO);
    check("timeout clk_oe", {31'd0, ps2_clk_oe}, 0);
    check("timeout dat_oe", {31'd0, ps2_dat_oe}, 0);
    check("timeout busy", {31'd0, tx_busy}, 0);
    check("timeout state", {29'd0, dbg_state}, 0);
    tick(1);
    check("timeout error_width", {31'd0, tx_error}, 0);
    check("timeout error_count", n_error - base_e, 1);
    check("timeout done_count", n_done - base_d, 0);

    // tx_start with 0x00 mid-frame must not disturb the 0xFF frame
    send_and_check("ff_inject", 8'hFF, 1'b1, 0, 3);
    base_d = n_done;
    tick(40);
    check("inject no_restart", {31'd0, tx_busy}, 0);
    check("inject single_done", n_done - base_d, 0);

    // reset during data bit 4 (0xE0 drives it as 0, so dat_oe is pulled)
    start_tx(8'hE0);
    run_inhibit("abort");
    kbd_frame("abort", 1'b1, 0, 0, 5, bits, ab);
    check("abort taken", {31'd0, ab}, 1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("abort idle", {29'd0, dbg_state}, 0);
    send_and_check("01_after_reset", 8'h01, 1'b1, 0, 0);

    // device holds data low after ACK, then back-to-back transfer
    send_and_check("ff_hold", 8'hFF, 1'b1, 100, 0);
    send_and_check("f4_b2b", 8'hF4, 1'b1, 0, 0);

    check("never_both_pulses", n_both, 0);
    check("scoreboard drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
